// File: rtl/alu_issue_stage_if.sv
// Handshake bundle between the upstream fetch/regfile side, the ALU issue stage and execute.
interface alu_issue_stage_if #(
    parameter int unsigned DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       inst;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        alu_func;
    logic [DATA_W-1:0] alu_op1;
    logic [DATA_W-1:0] alu_op2;
    logic [4:0]        rd;
    logic              rd_we;
    logic              illegal;

    modport master (
        output in_valid, inst, pc, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, alu_func, alu_op1, alu_op2, rd, rd_we, illegal
    );

    modport slave (
        input  in_valid, inst, pc, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, alu_func, alu_op1, alu_op2, rd, rd_we, illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I ALU-class decode/issue stage: decodes func/operands and registers them toward
// execute through an output register backed by a one-entry skid, keeping in_ready registered.
module alu_issue_stage #(
    parameter int unsigned DATA_W = 32
) (
    input logic              clk,
    input logic              rst_n,
    alu_issue_stage_if.slave bus
);
    localparam int unsigned FUNC_W = 4;
    localparam int unsigned RD_W   = 5;

    localparam logic [FUNC_W-1:0] F_ZERO = 4'd0;
    localparam logic [FUNC_W-1:0] F_ADD  = 4'd1;
    localparam logic [FUNC_W-1:0] F_SUB  = 4'd2;
    localparam logic [FUNC_W-1:0] F_SLL  = 4'd3;
    localparam logic [FUNC_W-1:0] F_SLT  = 4'd4;
    localparam logic [FUNC_W-1:0] F_XOR  = 4'd5;
    localparam logic [FUNC_W-1:0] F_OR   = 4'd6;
    localparam logic [FUNC_W-1:0] F_AND  = 4'd7;
    localparam logic [FUNC_W-1:0] F_SRL  = 4'd8;
    localparam logic [FUNC_W-1:0] F_SRA  = 4'd9;
    localparam logic [FUNC_W-1:0] F_SLTU = 4'd10;

    localparam logic [6:0] OPC_OP    = 7'h33;
    localparam logic [6:0] OPC_IMM   = 7'h13;
    localparam logic [6:0] OPC_LUI   = 7'h37;
    localparam logic [6:0] OPC_AUIPC = 7'h17;
    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;

    typedef struct packed {
        logic [FUNC_W-1:0] func;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [RD_W-1:0]   rd;
        logic              rd_we;
        logic              illegal;
    } issue_t;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FULL,
        S_SKID
    } state_t;

    state_t            state, state_nxt;
    issue_t            dec_c, out_q, skid_q;
    logic              legal_c;
    logic              in_ready_q, out_valid_q;
    logic              in_fire_c, load_in_c, load_skid_c, skid_to_out_c;
    logic [6:0]        opcode_c, f7_c;
    logic [2:0]        f3_c;
    logic [DATA_W-1:0] imm_i_c, imm_u_c, shamt_c;
    logic              unused_rs1_field_c;

    function automatic logic [FUNC_W-1:0] base_func(input logic [2:0] f3);
        case (f3)
            3'b000:  base_func = F_ADD;
            3'b001:  base_func = F_SLL;
            3'b010:  base_func = F_SLT;
            3'b011:  base_func = F_SLTU;
            3'b100:  base_func = F_XOR;
            3'b101:  base_func = F_SRL;
            3'b110:  base_func = F_OR;
            default: base_func = F_AND;
        endcase
    endfunction

    assign opcode_c           = bus.inst[6:0];
    assign f3_c               = bus.inst[14:12];
    assign f7_c               = bus.inst[31:25];
    assign imm_i_c            = DATA_W'($signed(bus.inst[31:20]));
    assign imm_u_c            = DATA_W'({bus.inst[31:12], 12'h000});
    assign shamt_c            = DATA_W'(bus.inst[24:20]);
    assign unused_rs1_field_c = ^bus.inst[19:15];

    // Decode; undecodable words collapse to a zero-operand illegal entry that still issues.
    always_comb begin
        dec_c    = '0;
        legal_c  = 1'b1;
        dec_c.rd = bus.inst[11:7];
        case (opcode_c)
            OPC_OP: begin
                dec_c.op1 = bus.rs1_data;
                dec_c.op2 = bus.rs2_data;
                if (f7_c == F7_BASE)                        dec_c.func = base_func(f3_c);
                else if (f7_c == F7_ALT && f3_c == 3'b000)  dec_c.func = F_SUB;
                else if (f7_c == F7_ALT && f3_c == 3'b101)  dec_c.func = F_SRA;
                else                                        legal_c    = 1'b0;
            end
            OPC_IMM: begin
                dec_c.op1 = bus.rs1_data;
                dec_c.op2 = imm_i_c;
                case (f3_c)
                    3'b001: begin
                        dec_c.op2 = shamt_c;
                        if (f7_c == F7_BASE) dec_c.func = F_SLL;
                        else                 legal_c    = 1'b0;
                    end
                    3'b101: begin
                        dec_c.op2 = shamt_c;
                        if (f7_c == F7_BASE)     dec_c.func = F_SRL;
                        else if (f7_c == F7_ALT) dec_c.func = F_SRA;
                        else                     legal_c    = 1'b0;
                    end
                    default: dec_c.func = base_func(f3_c);
                endcase
            end
            OPC_LUI: begin
                dec_c.func = F_ADD;
                dec_c.op2  = imm_u_c;
            end
            OPC_AUIPC: begin
                dec_c.func = F_ADD;
                dec_c.op1  = bus.pc;
                dec_c.op2  = imm_u_c;
            end
            default: legal_c = 1'b0;
        endcase
        if (!legal_c) begin
            dec_c.func = F_ZERO;
            dec_c.op1  = '0;
            dec_c.op2  = '0;
        end
        dec_c.illegal = !legal_c;
        dec_c.rd_we   = legal_c && (dec_c.rd != 5'd0);
    end

    assign in_fire_c = bus.in_valid && in_ready_q;

    // Occupancy FSM: EMPTY, output reg only, output reg plus skid.
    always_comb begin
        state_nxt     = state;
        load_in_c     = 1'b0;
        load_skid_c   = 1'b0;
        skid_to_out_c = 1'b0;
        case (state)
            S_EMPTY: begin
                if (in_fire_c) begin
                    load_in_c = 1'b1;
                    state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (bus.out_ready) begin
                    if (in_fire_c) load_in_c = 1'b1;
                    else           state_nxt = S_EMPTY;
                end else if (in_fire_c) begin
                    load_skid_c = 1'b1;
                    state_nxt   = S_SKID;
                end
            end
            S_SKID: begin
                if (bus.out_ready) begin
                    skid_to_out_c = 1'b1;
                    state_nxt     = S_FULL;
                end
            end
            default: state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state       <= state_nxt;
            out_valid_q <= (state_nxt != S_EMPTY);
            in_ready_q  <= (state_nxt != S_SKID);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_in_c)          out_q <= dec_c;
            else if (skid_to_out_c) out_q <= skid_q;
            if (load_skid_c)        skid_q <= dec_c;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.alu_func  = out_q.func;
    assign bus.alu_op1   = out_q.op1;
    assign bus.alu_op2   = out_q.op2;
    assign bus.rd        = out_q.rd;
    assign bus.rd_we     = out_q.rd_we;
    assign bus.illegal   = out_q.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed decode/stall/reset steps plus random traffic
// checked against an in-order queue model of the stage.
module tb_alu_issue_stage;
    localparam int unsigned DATA_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_stage_if #(.DATA_W(DATA_W)) bus ();

    alu_issue_stage #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0]  func;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference decode straight from the instruction-set rules.
    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] p,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [3:0]  tbl [8] = '{4'd1, 4'd3, 4'd4, 4'd10, 4'd5, 4'd8, 4'd6, 4'd7};
        logic [6:0]  opc = i[6:0];
        logic [2:0]  f3  = i[14:12];
        logic [6:0]  f7  = i[31:25];
        logic [31:0] imm = 32'($signed(i[31:20]));
        logic [31:0] upp = {i[31:12], 12'h000};
        logic        ok  = 1'b0;
        logic        sh  = (f3 == 3'd1) || (f3 == 3'd5);
        exp_t        e;
        e.func = 4'd0; e.op1 = 32'd0; e.op2 = 32'd0; e.rd = i[11:7];
        if (opc == 7'h33) begin
            ok     = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            e.func = (f7 == 7'h20) ? ((f3 == 3'd0) ? 4'd2 : 4'd9) : tbl[f3];
            e.op1  = a;
            e.op2  = b;
        end else if (opc == 7'h13) begin
            ok     = !sh || (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
            e.func = (f3 == 3'd5 && f7 == 7'h20) ? 4'd9 : tbl[f3];
            e.op1  = a;
            e.op2  = sh ? 32'(i[24:20]) : imm;
        end else if (opc == 7'h37 || opc == 7'h17) begin
            ok     = 1'b1;
            e.func = 4'd1;
            e.op1  = (opc == 7'h17) ? p : 32'd0;
            e.op2  = upp;
        end
        if (!ok) begin
            e.func = 4'd0; e.op1 = 32'd0; e.op2 = 32'd0;
        end
        e.illegal = !ok;
        e.rd_we   = ok && (e.rd != 5'd0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(q.size() > 0));
        chk({tag, "_in_ready"},  32'(bus.in_ready),  32'(q.size() < 2));
        if (q.size() > 0) begin
            chk({tag, "_func"},    32'(bus.alu_func), 32'(q[0].func));
            chk({tag, "_op1"},     bus.alu_op1,       q[0].op1);
            chk({tag, "_op2"},     bus.alu_op2,       q[0].op2);
            chk({tag, "_rd"},      32'(bus.rd),       32'(q[0].rd));
            chk({tag, "_rd_we"},   32'(bus.rd_we),    32'(q[0].rd_we));
            chk({tag, "_illegal"}, 32'(bus.illegal),  32'(q[0].illegal));
        end
    endtask

    // One clock: drive, let the edge happen, advance the model, then compare.
    task automatic cycle(input logic v, input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic ordy, input string tag);
        bit can_take;
        bit ofire;
        bus.in_valid = v; bus.inst = i; bus.pc = p;
        bus.rs1_data = a; bus.rs2_data = b; bus.out_ready = ordy;
        @(posedge clk);
        can_take = (q.size() < 2);
        ofire    = (q.size() > 0) && ordy;
        if (ofire) void'(q.pop_front());
        if (v && can_take) q.push_back(ref_decode(i, p, a, b));
        #1;
        check_state(tag);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w  = $urandom;
        logic [6:0]  f7;
        case ($urandom_range(0, 2))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            default: f7 = 7'h01;
        endcase
        case ($urandom_range(0, 5))
            0: begin w[6:0] = 7'h33; w[31:25] = f7; end
            1: begin w[6:0] = 7'h13; if ($urandom_range(0, 1) == 1) w[31:25] = f7; end
            2: w[6:0] = 7'h37;
            3: w[6:0] = 7'h17;
            4: w[6:0] = 7'h6F;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        bus.in_valid = 1'b0; bus.inst = 32'd0; bus.pc = 32'd0;
        bus.rs1_data = 32'd0; bus.rs2_data = 32'd0; bus.out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_func",      32'(bus.alu_func),  32'd0);
        chk("rst_op1",       bus.alu_op1,        32'd0);
        chk("rst_op2",       bus.alu_op2,        32'd0);
        chk("rst_rd_we",     32'(bus.rd_we),     32'd0);
        chk("rst_illegal",   32'(bus.illegal),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        cycle(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b1, "add");
        chk("add_func", 32'(bus.alu_func), 32'd1);
        chk("add_op1", bus.alu_op1, 32'd5);
        chk("add_op2", bus.alu_op2, 32'd7);
        chk("add_rd", 32'(bus.rd), 32'd3);
        chk("add_rd_we", 32'(bus.rd_we), 32'd1);
        cycle(1'b1, 32'h402081B3, 32'h0, 32'd9, 32'd4, 1'b1, "sub");
        chk("sub_func", 32'(bus.alu_func), 32'd2);
        cycle(1'b1, 32'h40435293, 32'h0, 32'h8000_0000, 32'd1, 1'b1, "srai");
        chk("srai_func", 32'(bus.alu_func), 32'd9);
        chk("srai_op2", bus.alu_op2, 32'd4);
        cycle(1'b1, 32'hFFF00093, 32'h0, 32'd0, 32'd3, 1'b1, "addi");
        chk("addi_func", 32'(bus.alu_func), 32'd1);
        chk("addi_op2", bus.alu_op2, 32'hFFFF_FFFF);
        cycle(1'b1, 32'h123450B7, 32'h40, 32'd11, 32'd12, 1'b1, "lui");
        chk("lui_op1", bus.alu_op1, 32'd0);
        chk("lui_op2", bus.alu_op2, 32'h1234_5000);
        cycle(1'b1, 32'h12345097, 32'h100, 32'd11, 32'd12, 1'b1, "auipc");
        chk("auipc_op1", bus.alu_op1, 32'h100);
        cycle(1'b1, 32'h0000006F, 32'h0, 32'd1, 32'd2, 1'b1, "jal");
        chk("jal_illegal", 32'(bus.illegal), 32'd1);
        chk("jal_func", 32'(bus.alu_func), 32'd0);
        cycle(1'b1, 32'h022081B3, 32'h0, 32'd1, 32'd2, 1'b1, "mul");
        chk("mul_illegal", 32'(bus.illegal), 32'd1);
        chk("mul_rd_we", 32'(bus.rd_we), 32'd0);
        cycle(1'b1, 32'h00208033, 32'h0, 32'd1, 32'd2, 1'b1, "add_x0");
        chk("x0_rd_we", 32'(bus.rd_we), 32'd0);
        chk("x0_illegal", 32'(bus.illegal), 32'd0);
        cycle(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, "drain0");

        cycle(1'b1, 32'h002081B3, 32'h0, 32'd21, 32'd1, 1'b0, "stall1");
        cycle(1'b1, 32'h402081B3, 32'h0, 32'd22, 32'd2, 1'b0, "stall2");
        chk("stall2_in_ready", 32'(bus.in_ready), 32'd0);
        cycle(1'b1, 32'h00C0C233, 32'h0, 32'd23, 32'd3, 1'b0, "stall3");
        chk("stall3_op1", bus.alu_op1, 32'd21);
        cycle(1'b1, 32'h00C0C233, 32'h0, 32'd23, 32'd3, 1'b1, "rel1");
        chk("rel1_op1", bus.alu_op1, 32'd22);
        cycle(1'b1, 32'h00C0C233, 32'h0, 32'd23, 32'd3, 1'b1, "rel2");
        chk("rel2_op1", bus.alu_op1, 32'd23);
        cycle(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, "rel3");

        cycle(1'b1, 32'h002081B3, 32'h0, 32'd31, 32'd1, 1'b0, "fill1");
        cycle(1'b1, 32'h002081B3, 32'h0, 32'd32, 32'd1, 1'b0, "fill2");
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("mid_rst_op1",       bus.alu_op1,        32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, "post_rst1");
        cycle(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, "post_rst2");

        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 3) != 0, rand_inst(), $urandom, $urandom, $urandom,
                  $urandom_range(0, 2) != 0, "rnd");
        end
        for (int n = 0; n < 4; n++) begin
            cycle(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, "final_drain");
        end
        chk("final_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
